// File: rtl/avalon16_wb32_pkg.sv
// Shared definitions for the Avalon-16 to Wishbone-32 bridge.
package avalon16_wb32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] ERR_DATA = 16'hDEAD;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Counts Wishbone bus cycles and flags the cycle on which TIMEOUT is reached.
module wb_timeout_cnt #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [7:0] cnt;

  // cnt holds the number of bus cycles already completed, so the current cycle is cnt+1
  assign expired = en & (({1'b0, cnt} + 9'd1) >= {1'b0, TIMEOUT});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             cnt <= 8'd0;
    else if (clr)             cnt <= 8'd0;
    else if (en && !expired)  cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/avalon16_wb32.sv
// Avalon-MM 16-bit slave to Wishbone classic 32-bit master bridge, one
// transfer in flight, with sticky error flag and bus timeout.
module avalon16_wb32
  import avalon16_wb32_pkg::*;
#(
  parameter logic [31:0] WB_BASE = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        avs_chipselect_i,
  input  logic [21:0] avs_address_i,
  input  logic [1:0]  avs_byteenable_n_i,
  input  logic        avs_read_n_i,
  input  logic        avs_write_n_i,
  input  logic [15:0] avs_writedata_i,
  output logic [15:0] avs_readdata_o,
  output logic        avs_waitrequest_o,
  output logic        avs_readdatavalid_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_data_o,
  input  logic [31:0] wbm_data_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        bus_error_o
);

  state_t state, state_nxt;
  logic   wr_req, rd_req, accept, wr_empty;
  logic   bus_end, bus_err, tmo;
  logic   hi_q, rd_q;

  assign wr_req   = avs_chipselect_i & ~avs_write_n_i;
  assign rd_req   = avs_chipselect_i & ~avs_read_n_i & avs_write_n_i;
  assign accept   = (state == IDLE) & (wr_req | rd_req);
  assign wr_empty = &avs_byteenable_n_i;

  assign avs_waitrequest_o   = (state != IDLE);
  assign avs_readdatavalid_o = (state == RESP) & rd_q;
  assign wbm_stb_o           = wbm_cyc_o;

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state == BUS),
    .clr     (state != BUS),
    .expired (tmo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus_end   = 1'b0;
    bus_err   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req)      state_nxt = wr_empty ? RESP : BUS;
        else if (rd_req) state_nxt = BUS;
      end
      BUS: begin
        // an ack landing on the final allowed cycle still counts as success
        bus_err = wbm_err_i | (tmo & ~wbm_ack_i);
        bus_end = wbm_ack_i | bus_err;
        if (bus_end) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbm_addr_o     <= 32'd0;
      wbm_data_o     <= 32'd0;
      wbm_sel_o      <= 4'd0;
      wbm_we_o       <= 1'b0;
      wbm_cyc_o      <= 1'b0;
      hi_q           <= 1'b0;
      rd_q           <= 1'b0;
      avs_readdata_o <= 16'd0;
      bus_error_o    <= 1'b0;
    end else begin
      if (accept) begin
        wbm_addr_o <= WB_BASE + {9'd0, avs_address_i[21:1], 2'b00};
        wbm_data_o <= avs_address_i[0] ? {avs_writedata_i, 16'd0} : {16'd0, avs_writedata_i};
        if (rd_req)                wbm_sel_o <= 4'b1111;
        else if (avs_address_i[0]) wbm_sel_o <= {~avs_byteenable_n_i, 2'b00};
        else                       wbm_sel_o <= {2'b00, ~avs_byteenable_n_i};
        wbm_we_o  <= wr_req & ~wr_empty;
        wbm_cyc_o <= rd_req | ~wr_empty;
        hi_q      <= avs_address_i[0];
        rd_q      <= rd_req;
      end
      if ((state == BUS) && bus_end) begin
        wbm_cyc_o <= 1'b0;
        wbm_we_o  <= 1'b0;
        if (rd_q)
          avs_readdata_o <= bus_err ? ERR_DATA : (hi_q ? wbm_data_i[31:16] : wbm_data_i[15:0]);
        if (bus_err) bus_error_o <= 1'b1;
      end
    end
  end

endmodule
